// File: rtl/pu_pkg.sv
// Shared response codes and FSM state encodings for the protection-unit deny responder.
package pu_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WIDLE  = 2'd0,
        WDRAIN = 2'd1,
        WRESP  = 2'd2
    } wstate_e;

    typedef enum logic {
        RIDLE = 1'b0,
        RDATA = 1'b1
    } rstate_e;

endpackage

// File: rtl/pu_deny_responder.sv
// AXI slave that absorbs denied transactions and answers them with SLVERR.
// Optional per-direction deny counters are enabled with PU_DENY_STATS_EN.
module pu_deny_responder
    import pu_pkg::*;
#(
    parameter int unsigned C_ID_WIDTH   = 1,
    parameter int unsigned C_DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [C_ID_WIDTH-1:0]   s_awid,
    input  logic [7:0]              s_awlen,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    input  logic                    s_wlast,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic [C_ID_WIDTH-1:0]   s_bid,
    output logic [1:0]              s_bresp,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    input  logic [C_ID_WIDTH-1:0]   s_arid,
    input  logic [7:0]              s_arlen,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [C_ID_WIDTH-1:0]   s_rid,
    output logic [C_DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast
`ifdef PU_DENY_STATS_EN
    ,
    output logic [15:0]             wr_deny_cnt,
    output logic [15:0]             rd_deny_cnt
`endif
);

    wstate_e    wstate;
    rstate_e    rstate;
    logic [7:0] beat_cnt;
    logic [7:0] len_q;

    // The write burst ends on wlast, so the advertised length is not needed.
    logic unused_awlen;
    assign unused_awlen = ^s_awlen;

    assign s_rdata = '0;

    // Write path: accept AW, drain W until wlast, then return SLVERR on B.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstate    <= WIDLE;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bid     <= '0;
            s_bresp   <= RESP_OKAY;
        end else begin
            case (wstate)
                WIDLE: begin
                    s_awready <= 1'b1;
                    if (s_awvalid && s_awready) begin
                        s_bid     <= s_awid;
                        s_awready <= 1'b0;
                        s_wready  <= 1'b1;
                        wstate    <= WDRAIN;
                    end
                end
                WDRAIN: begin
                    if (s_wvalid && s_wready && s_wlast) begin
                        s_wready <= 1'b0;
                        s_bvalid <= 1'b1;
                        s_bresp  <= RESP_SLVERR;
                        wstate   <= WRESP;
                    end
                end
                WRESP: begin
                    if (s_bvalid && s_bready) begin
                        s_bvalid  <= 1'b0;
                        s_awready <= 1'b1;
                        wstate    <= WIDLE;
                    end
                end
                default: begin
                    s_awready <= 1'b0;
                    s_wready  <= 1'b0;
                    s_bvalid  <= 1'b0;
                    wstate    <= WIDLE;
                end
            endcase
        end
    end

    // Read path: accept AR, then emit arlen+1 zero beats with SLVERR.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rstate    <= RIDLE;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rid     <= '0;
            s_rresp   <= RESP_OKAY;
            s_rlast   <= 1'b0;
            beat_cnt  <= 8'd0;
            len_q     <= 8'd0;
        end else begin
            case (rstate)
                RIDLE: begin
                    s_arready <= 1'b1;
                    if (s_arvalid && s_arready) begin
                        s_rid     <= s_arid;
                        len_q     <= s_arlen;
                        beat_cnt  <= 8'd0;
                        s_arready <= 1'b0;
                        s_rvalid  <= 1'b1;
                        s_rresp   <= RESP_SLVERR;
                        s_rlast   <= (s_arlen == 8'd0);
                        rstate    <= RDATA;
                    end
                end
                RDATA: begin
                    if (s_rvalid && s_rready) begin
                        if (s_rlast) begin
                            s_rvalid  <= 1'b0;
                            s_rlast   <= 1'b0;
                            s_arready <= 1'b1;
                            rstate    <= RIDLE;
                        end else begin
                            // The last beat exits before incrementing, so 255 never wraps.
                            beat_cnt <= 8'(beat_cnt + 8'd1);
                            s_rlast  <= (8'(beat_cnt + 8'd1) == len_q);
                        end
                    end
                end
                default: begin
                    s_arready <= 1'b0;
                    s_rvalid  <= 1'b0;
                    s_rlast   <= 1'b0;
                    rstate    <= RIDLE;
                end
            endcase
        end
    end

`ifdef PU_DENY_STATS_EN
    // Saturating counts of completed denied writes (B) and reads (R last).
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_deny_cnt <= 16'd0;
            rd_deny_cnt <= 16'd0;
        end else begin
            if (s_bvalid && s_bready && (wr_deny_cnt != 16'hFFFF)) begin
                wr_deny_cnt <= 16'(wr_deny_cnt + 16'd1);
            end
            if (s_rvalid && s_rready && s_rlast && (rd_deny_cnt != 16'hFFFF)) begin
                rd_deny_cnt <= 16'(rd_deny_cnt + 16'd1);
            end
        end
    end
`endif

endmodule

// File: doc/pu_deny_responder.md
PU_DENY_RESPONDER -- requirements
Module: pu_deny_responder

Interface
REQ-001 C_ID_WIDTH, default 1, width of AXI ID fields.
REQ-002 C_DATA_WIDTH, default 32, width of read data bus.
REQ-003 ACLK  in  1  single clock; all logic rising-edge.
REQ-004 ARESETN  in  1  asynchronous, active-low reset.
REQ-005 s_awvalid  in  1  denied write address valid from protection unit.
REQ-006 s_awready  out  1  write address accept.
REQ-007 s_awid  in  C_ID_WIDTH  write ID.
REQ-008 s_awlen  in  8  write burst length minus one.
REQ-009 s_wvalid  in  1  write beat valid; data and strobes are not ported and are discarded.
REQ-010 s_wready  out  1  write beat accept.
REQ-011 s_wlast  in  1  final write beat.
REQ-012 s_bvalid  out  1  write response valid.
REQ-013 s_bready  in  1  write response accept.
REQ-014 s_bid  out  C_ID_WIDTH  captured AW ID.
REQ-015 s_bresp  out  2  write response code.
REQ-016 s_arvalid  in  1  denied read address valid.
REQ-017 s_arready  out  1  read address accept.
REQ-018 s_arid  in  C_ID_WIDTH  read ID.
REQ-019 s_arlen  in  8  read burst length minus one.
REQ-020 s_rvalid  out  1  read beat valid.
REQ-021 s_rready  in  1  read beat accept.
REQ-022 s_rid  out  C_ID_WIDTH  captured AR ID.
REQ-023 s_rdata  out  C_DATA_WIDTH  read data, always zero.
REQ-024 s_rresp  out  2  read response code.
REQ-025 s_rlast  out  1  final read beat.

Function
REQ-026 Write and read paths SHALL be independent FSMs; concurrent activity on both SHALL NOT stall either.
REQ-027 Write FSM states WIDLE, WDRAIN, WRESP: s_awready=1 only in WIDLE; AW handshake captures awid and goes to WDRAIN.
REQ-028 In WDRAIN, s_wready=1 starting the cycle after the AW handshake; every W handshake is consumed, and a handshake with s_wlast=1 goes to WRESP regardless of awlen.
REQ-029 In WRESP, s_bvalid=1 starting the cycle after the wlast handshake, with s_bresp=2'b10 (SLVERR) and s_bid=captured ID; outputs hold stable until s_bready, then the FSM returns to WIDLE.
REQ-030 W beats presented while in WIDLE or WRESP SHALL see s_wready=0.
REQ-031 Read FSM states RIDLE, RDATA: s_arready=1 only in RIDLE; AR handshake captures arid and arlen, clears the 8-bit beat counter and goes to RDATA.
REQ-032 In RDATA, s_rvalid=1 starting the cycle after the AR handshake, with s_rresp=2'b10, s_rdata=0 and s_rid=captured ID; the counter increments on each R handshake.
REQ-033 s_rlast=1 exactly when counter==captured arlen; that handshake returns the FSM to RIDLE; arlen=255 yields 256 beats without counter overflow.
REQ-034 R outputs SHALL hold stable while s_rvalid=1 and s_rready=0.

Reset
REQ-035 ARESETN low SHALL asynchronously force WIDLE/RIDLE, clear the counter and captured IDs, and drive all valid/ready outputs, s_bresp, s_rresp, s_rlast and s_rdata to 0; in-flight bursts are abandoned, and s_awready/s_arready rise on the first clock after deassertion.

Configuration
REQ-036 With PU_DENY_STATS_EN defined, the block SHALL add outputs wr_deny_cnt[15:0] and rd_deny_cnt[15:0], which increment on each B or R-last handshake, saturate at 16'hFFFF and reset to 0; without the macro these ports and counters SHALL NOT exist.

Structure
REQ-037 A shared package pu_pkg SHALL hold the response constants RESP_OKAY/RESP_SLVERR/RESP_DECERR and the FSM state enums; no sub-module is used.

Verification
REQ-038 AW id=1, len=7, then 8 W beats with wlast on beat 8 -> 8 wready handshakes, one B with bid=1 and bresp=2'b10 the cycle after the last beat.
REQ-039 AR id=0, len=7, rready=1 -> 8 R beats on consecutive cycles, rdata=0, rresp=2'b10, rlast only on beat 8.
REQ-040 AR len=255 with rready toggling 1/0 -> 256 beats, outputs stable during stalls, rlast on beat 256.
REQ-041 Write burst and read burst issued in the same cycle -> both complete with no interleaving stalls.
REQ-042 ARESETN pulsed low during read beat 3 of len=7 -> rvalid=0 immediately, and arready=1 on the first clock after release.
REQ-043 With PU_DENY_STATS_EN, 3 denied writes and 2 denied reads -> wr_deny_cnt=3 and rd_deny_cnt=2.
